// File: rtl/io_mbox_pkg.sv
// Shared definitions for the I/O mailbox responder.
// Holds the command opcodes, PORT_C / PORT_B field positions and the FSM state encoding.
package io_mbox_pkg;

    // Command opcodes carried in PORT_C[30:28]
    localparam logic [2:0] OpNop   = 3'b000;
    localparam logic [2:0] OpWrite = 3'b001;
    localparam logic [2:0] OpRead  = 3'b010;
    localparam logic [2:0] OpAdd   = 3'b011;
    localparam logic [2:0] OpClear = 3'b100;

    // PORT_C fields
    localparam int unsigned CReqBit = 31;
    localparam int unsigned COpMsb  = 30;
    localparam int unsigned COpLsb  = 28;

    // PORT_B fields
    localparam int unsigned BAckBit  = 31;
    localparam int unsigned BBusyBit = 30;
    localparam int unsigned BErrBit  = 29;
    localparam int unsigned BCntMsb  = 15;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StExec,
        StClr,
        StResp
    } state_e;

endpackage

// File: rtl/io_mbox_regfile.sv
// Scratchpad register file for the mailbox responder.
// DEPTH x 32 bits, one synchronous write port, one combinational read port,
// every entry cleared by the asynchronous active-low reset.
//   CLK      clock
//   RST      asynchronous reset, active-low
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
module io_mbox_regfile #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/io_mailbox_responder.sv
// Port-side agent for the memory-mapped I/O mailbox.
// Software posts a command on PORT_C (toggling REQ) with an operand on PORT_D, then
// polls PORT_B until ACK matches REQ and reads the result from PORT_A. Commands act
// on a small scratchpad after a programmable number of wait states.
//   CLK     clock
//   RST     asynchronous reset, active-low
//   PORT_C  command: [31] REQ toggle, [30:28] OP, [AW-1:0] ADDR
//   PORT_D  write operand
//   PORT_A  result register
//   PORT_B  status: [31] ACK, [30] BUSY, [29] ERR, [15:0] transaction count
module io_mailbox_responder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PORT_C,
    input  logic [31:0] PORT_D,
    output logic [31:0] PORT_A,
    output logic [31:0] PORT_B
);

    import io_mbox_pkg::*;

    localparam int unsigned WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e         state_q, state_d;
    logic           ack_q, ack_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [31:0]    res_q, res_d;
    logic           req_q, req_d;
    logic [2:0]     op_q, op_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [AW-1:0]  clr_idx_q, clr_idx_d;

    logic           rf_we;
    logic [AW-1:0]  rf_waddr;
    logic [31:0]    rf_wdata;
    logic [31:0]    rf_rdata;
    logic           req_pending;
    logic           unused_port_c;

    // Bits between OP and ADDR carry no meaning
    assign unused_port_c = ^PORT_C[COpLsb-1:AW];

    assign req_pending = PORT_C[CReqBit] != ack_q;

    io_mbox_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata),
        .raddr_i (addr_q),
        .rdata_o (rf_rdata)
    );

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        req_d     = req_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wait_d    = wait_q;
        clr_idx_d = clr_idx_q;
        rf_we     = 1'b0;
        rf_waddr  = addr_q;
        rf_wdata  = data_q;

        unique case (state_q)
            StIdle: begin
                if (req_pending) begin
                    req_d  = PORT_C[CReqBit];
                    op_d   = PORT_C[COpMsb:COpLsb];
                    addr_d = PORT_C[AW-1:0];
                    data_d = PORT_D;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (WAIT_CYCLES > 0) begin
                        wait_d  = WCW'(WAIT_CYCLES);
                        state_d = StWait;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StWait: begin
                wait_d = wait_q - WCW'(1);
                if (wait_q == WCW'(1)) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
                case (op_q)
                    OpNop: ;
                    OpWrite: begin
                        rf_we = 1'b1;
                        res_d = data_q;
                    end
                    OpRead: begin
                        res_d = rf_rdata;
                    end
                    OpAdd: begin
                        rf_we    = 1'b1;
                        rf_wdata = rf_rdata + data_q;
                        res_d    = rf_rdata + data_q;
                    end
                    OpClear: begin
                        res_d     = '0;
                        clr_idx_d = '0;
                        state_d   = StClr;
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
            StClr: begin
                // One entry per cycle through the normal write port
                rf_we     = 1'b1;
                rf_waddr  = clr_idx_q;
                rf_wdata  = '0;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                ack_d   = req_q;
                busy_d  = 1'b0;
                cnt_d   = cnt_q + 16'd1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            req_q     <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wait_q    <= '0;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            req_q     <= req_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wait_q    <= wait_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign PORT_A = res_q;

    always_comb begin
        PORT_B              = '0;
        PORT_B[BAckBit]     = ack_q;
        PORT_B[BBusyBit]    = busy_q;
        PORT_B[BErrBit]     = err_q;
        PORT_B[BCntMsb:0]   = cnt_q;
    end

endmodule

// File: tb/tb_io_mailbox_responder.sv
// Self-checking bench for io_mailbox_responder: directed scenarios followed by random
// commands, all checked against a transaction-level model of the mailbox.
module tb_io_mailbox_responder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned W     = 2;

    logic        CLK;
    logic        RST;
    logic [31:0] PORT_C;
    logic [31:0] PORT_D;
    logic [31:0] PORT_A;
    logic [31:0] PORT_B;

    io_mailbox_responder #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .PORT_C (PORT_C),
        .PORT_D (PORT_D),
        .PORT_A (PORT_A),
        .PORT_B (PORT_B)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_res;
    logic        m_err;
    logic        m_ack;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_res = '0;
        m_err = 1'b0;
        m_ack = 1'b0;
        m_cnt = '0;
    endtask

    function automatic logic [31:0] exp_status();
        return {m_ack, 1'b0, m_err, 13'd0, m_cnt};
    endfunction

    // Issue one command and follow it to completion. With disturb set, PORT_C/PORT_D
    // are scribbled on while busy (REQ toggled away and back) and must be ignored.
    task automatic run_req(input logic [2:0] op, input logic [3:0] addr,
                           input logic [31:0] data, input bit disturb);
        logic        req;
        logic [31:0] exp_res;
        logic        exp_err;
        int          lat;
        int          n;

        req     = ~m_ack;
        exp_res = m_res;
        exp_err = 1'b0;
        case (op)
            3'd1: begin m_mem[addr] = data; exp_res = data; end
            3'd2: exp_res = m_mem[addr];
            3'd3: begin m_mem[addr] = m_mem[addr] + data; exp_res = m_mem[addr]; end
            3'd4: begin
                for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
                exp_res = '0;
            end
            3'd5, 3'd6, 3'd7: exp_err = 1'b1;
            default: ;
        endcase
        lat = (op == 3'd4) ? int'(W + DEPTH + 2) : int'(W + 2);

        @(negedge CLK);
        PORT_D = data;
        PORT_C = {req, op, 24'($urandom), addr};
        @(posedge CLK);
        #1;
        check("busy_at_k", {31'd0, PORT_B[30]}, 32'd1);
        n = 0;
        while (PORT_B[31] == m_ack && n < lat + 20) begin
            if (disturb && n == 0) begin
                PORT_C = {~req, 3'b001, 24'd0, ~addr};
                PORT_D = ~data;
            end
            if (disturb && n == 1) begin
                PORT_C = {req, 3'b010, 24'd0, addr + 4'd1};
            end
            @(posedge CLK);
            #1;
            n++;
            if (n == int'(W + 1)) begin
                check("res_at_exec", PORT_A, exp_res);
                check("err_at_exec", {31'd0, PORT_B[29]}, {31'd0, exp_err});
            end
        end
        m_ack = req;
        m_cnt = m_cnt + 16'd1;
        m_res = exp_res;
        m_err = exp_err;
        check("ack_latency", n, lat);
        check("status_done", PORT_B, exp_status());
        check("result_done", PORT_A, m_res);
        if (disturb) begin
            repeat (4) @(posedge CLK);
            #1;
            check("no_lost_req", PORT_B, exp_status());
        end
    endtask

    task automatic reset_mid_wait();
        @(negedge CLK);
        PORT_D = $urandom;
        PORT_C = {~m_ack, 3'b001, 24'd0, 4'd9};
        @(posedge CLK);
        #1;
        check("rst_busy", {31'd0, PORT_B[30]}, 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        PORT_C = '0;
        model_reset();
        check("rst_portb", PORT_B, 32'd0);
        check("rst_porta", PORT_A, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("rst_no_ack", PORT_B, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST    = 1'b0;
        PORT_C = '0;
        PORT_D = '0;
        model_reset();
        #22;
        check("reset_portb", PORT_B, 32'd0);
        check("reset_porta", PORT_A, 32'd0);
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            check("idle_portb", PORT_B, 32'd0);
        end
        check("idle_porta", PORT_A, 32'd0);

        // Write / add / read sequence
        run_req(3'b001, 4'd3, 32'hDEADBEEF, 1'b0);
        run_req(3'b011, 4'd3, 32'h00000001, 1'b0);
        run_req(3'b010, 4'd3, 32'h12345678, 1'b0);
        // Add wraps mod 2^32
        run_req(3'b001, 4'd5, 32'hFFFFFFFF, 1'b0);
        run_req(3'b011, 4'd5, 32'h00000002, 1'b0);
        // Clear, then confirm both entries are gone
        run_req(3'b100, 4'd0, 32'h0, 1'b0);
        run_req(3'b010, 4'd3, 32'h0, 1'b0);
        run_req(3'b010, 4'd5, 32'h0, 1'b0);
        // Illegal op sets ERR; the next valid command clears it
        run_req(3'b001, 4'd7, 32'hCAFEF00D, 1'b0);
        run_req(3'b111, 4'd7, 32'h55555555, 1'b0);
        run_req(3'b010, 4'd7, 32'h0, 1'b0);
        // Inputs changing while busy are ignored
        run_req(3'b011, 4'd7, 32'h00000010, 1'b1);
        // Reset during wait drops the request
        reset_mid_wait();
        run_req(3'b010, 4'd7, 32'h0, 1'b0);
        run_req(3'b010, 4'd3, 32'h0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [2:0]  op;
            logic [31:0] data;
            op   = 3'($urandom_range(0, 7));
            data = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 | 32'($urandom_range(0, 15))
                                              : $urandom;
            run_req(op, 4'($urandom_range(0, 15)), data, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
